ysyx_2022040010_uncache_bridge: RTL and testbench



---
 rtl/ysyx_2022040010_uncache_bridge.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_2022040010_uncache_bridge.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_uncache_bridge.sv
// ysyx_2022040010_uncache_bridge
//
// Single-beat AXI master for uncached LSU accesses. An uncached request seen
// in IDLE is latched, then one AXI read (AR/R) or write (AW/W/B) is run.
// `refresh` pulses for one cycle when the transaction ends. `rdata` carries
// the read data in that cycle and holds it until the next read completes.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   uncache, dsram_e, dsram_we    request qualifiers from the tag stage / LSU
//   dsram_sel/addr/wdata          byte strobe, byte address, write data
//   refresh, rdata, busy, err     completion pulse, read data, non-idle, response error
//   ar*, r*, aw*, w*, b*          AXI master channels (rdata_i is the R-channel data)
//
// Optional feature macro: YSYX_2022040010_UNCACHE_ERR_EN
//   defined   -> err is set from a non-zero rresp/bresp and is high only in the refresh cycle
//   undefined -> rresp/bresp are ignored and err is tied low
module ysyx_2022040010_uncache_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        uncache,
  input  logic        dsram_e,
  input  logic        dsram_we,
  input  logic [7:0]  dsram_sel,
  input  logic [63:0] dsram_addr,
  input  logic [63:0] dsram_wdata,
  output logic        refresh,
  output logic [63:0] rdata,
  output logic        busy,
  output logic        err,
  output logic [63:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [63:0] rdata_i,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [63:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WRITE = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  sel_q;
  logic        aw_done;
  logic        w_done;
  logic        req;
  logic        aw_hs;
  logic        w_hs;

  assign req   = dsram_e & uncache;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    refresh   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req) state_nxt = dsram_we ? WRITE : RADDR;
      end
      RADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RDATA;
      end
      RDATA: begin
        rready = 1'b1;
        if (rvalid) state_nxt = RDATA == state ? DONE : state;
      end
      WRITE: begin
        // Each channel's valid drops once its own handshake is recorded;
        // leave when both are done, counting a handshake in this cycle.
        awvalid = ~aw_done;
        wvalid  = ~w_done;
        if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = WRESP;
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = DONE;
      end
      DONE: begin
        refresh   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Request capture: outgoing address/data/strobe are the values latched in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      sel_q   <= 8'd0;
    end else if (state == IDLE && req) begin
      addr_q  <= dsram_addr;
      wdata_q <= dsram_wdata;
      sel_q   <= dsram_sel;
    end
  end

  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = sel_q;

  // Write channel completion flags, cleared before every new transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == IDLE) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == WRITE) begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  // Read data capture at the R handshake; held until the next read completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        rdata <= 64'd0;
    else if (state == RDATA && rvalid) rdata <= rdata_i;
  end

`ifdef YSYX_2022040010_UNCACHE_ERR_EN
  logic err_q;

  // Set only on the transition into DONE, so it clears on the following edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           err_q <= 1'b0;
    else if (state == RDATA && rvalid) err_q <= (rresp != 2'b00);
    else if (state == WRESP && bvalid) err_q <= (bresp != 2'b00);
    else                               err_q <= 1'b0;
  end

  assign err = err_q;
`else
  logic unused_resp;

  assign unused_resp = ^{rresp, bresp};
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_2022040010_uncache_bridge.sv
// Testbench for ysyx_2022040010_uncache_bridge: directed test-plan steps followed
// by randomized read/write transactions with random slave delays. Expected
// control waveforms come from closed-form cycle formulas of the transaction
// timing; the slave side reacts to the DUT valids with programmed delays.
module tb_ysyx_2022040010_uncache_bridge;

`ifdef YSYX_2022040010_UNCACHE_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        uncache;
  logic        dsram_e;
  logic        dsram_we;
  logic [7:0]  dsram_sel;
  logic [63:0] dsram_addr;
  logic [63:0] dsram_wdata;
  logic        refresh;
  logic [63:0] rdata;
  logic        busy;
  logic        err;
  logic [63:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata_i;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [63:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int errors = 0;
  int checks = 0;
  logic [63:0] last_rdata;

  ysyx_2022040010_uncache_bridge dut (
    .clk(clk), .rst(rst), .uncache(uncache), .dsram_e(dsram_e), .dsram_we(dsram_we),
    .dsram_sel(dsram_sel), .dsram_addr(dsram_addr), .dsram_wdata(dsram_wdata),
    .refresh(refresh), .rdata(rdata), .busy(busy), .err(err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata_i(rdata_i), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ctl();
    return {arvalid, rready, awvalid, wvalid, bready, refresh, busy, err};
  endfunction

  task automatic chk(input string tag, input logic [63:0] exp, input logic [63:0] obs);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One read transaction starting with the request in cycle 0. Expected:
  // arvalid cycles 1..1+d_ar, rready 2+d_ar..2+d_ar+d_r, refresh at 3+d_ar+d_r.
  task automatic do_read(input logic [63:0] a, input logic [63:0] d, input int d_ar,
                         input int d_r, input logic [1:0] resp, input bit hold);
    int fin;
    int ar_cnt;
    int r_cnt;
    bit r_pend;
    bit ar_hs;
    bit e_ref;
    logic [7:0] exp_ctl;
    fin = 3 + d_ar + d_r;
    ar_cnt = 0;
    r_cnt = 0;
    r_pend = 0;
    for (int c = 0; c <= fin; c++) begin
      @(negedge clk);
      e_ref = (c == fin);
      exp_ctl = {(c >= 1 && c <= 1 + d_ar), (c >= 2 + d_ar && c <= 2 + d_ar + d_r),
                 1'b0, 1'b0, 1'b0, e_ref, (c >= 1), (ERR_ON && e_ref && resp != 2'b00)};
      chk($sformatf("rd_ctl c%0d", c), {56'd0, exp_ctl}, {56'd0, ctl()});
      if (exp_ctl[7]) chk("araddr", a, araddr);
      if (e_ref) chk("rdata", d, rdata);
      dsram_e     = (c == 0) || hold;
      uncache     = 1'b1;
      dsram_we    = 1'b0;
      dsram_addr  = (c == 0 || hold) ? a : {$urandom, $urandom};
      dsram_wdata = {$urandom, $urandom};
      dsram_sel   = 8'($urandom);
      rresp       = resp;
      bresp       = 2'b11;
      rvalid      = r_pend && (r_cnt >= d_r);
      rdata_i     = rvalid ? d : {$urandom, $urandom};
      if (r_pend) r_cnt++;
      if (rvalid && rready) r_pend = 0;
      arready = arvalid && (ar_cnt == d_ar);
      ar_hs   = arvalid && arready;
      if (arvalid) ar_cnt++;
      if (ar_hs) r_pend = 1;
    end
    last_rdata = d;
  endtask

  // One write transaction: awvalid cycles 1..1+d_aw, wvalid 1..1+d_w,
  // bready from t2+1 where t2 is the later handshake, refresh at t2+2+d_b.
  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int d_aw, input int d_w, input int d_b, input logic [1:0] resp);
    int t2;
    int fin;
    int aw_cnt;
    int w_cnt;
    int b_cnt;
    bit aw_got;
    bit w_got;
    bit b_pend;
    bit b_done;
    bit e_ref;
    logic [7:0] exp_ctl;
    t2 = 1 + ((d_aw > d_w) ? d_aw : d_w);
    fin = t2 + 2 + d_b;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    aw_got = 0; w_got = 0; b_pend = 0; b_done = 0;
    for (int c = 0; c <= fin; c++) begin
      @(negedge clk);
      e_ref = (c == fin);
      exp_ctl = {1'b0, 1'b0, (c >= 1 && c <= 1 + d_aw), (c >= 1 && c <= 1 + d_w),
                 (c >= t2 + 1 && c <= t2 + 1 + d_b), e_ref, (c >= 1),
                 (ERR_ON && e_ref && resp != 2'b00)};
      chk($sformatf("wr_ctl c%0d", c), {56'd0, exp_ctl}, {56'd0, ctl()});
      if (exp_ctl[5]) chk("awaddr", a, awaddr);
      if (exp_ctl[4]) begin
        chk("wdata", d, wdata);
        chk("wstrb", {56'd0, s}, {56'd0, wstrb});
      end
      dsram_e     = (c == 0);
      uncache     = 1'b1;
      dsram_we    = 1'b1;
      dsram_addr  = (c == 0) ? a : {$urandom, $urandom};
      dsram_wdata = (c == 0) ? d : {$urandom, $urandom};
      dsram_sel   = (c == 0) ? s : 8'($urandom);
      rresp       = 2'b11;
      bresp       = resp;
      bvalid      = b_pend && (b_cnt >= d_b);
      if (b_pend) b_cnt++;
      if (bvalid && bready) begin
        b_pend = 0;
        b_done = 1;
      end
      awready = awvalid && (aw_cnt == d_aw);
      wready  = wvalid && (w_cnt == d_w);
      if (awvalid) aw_cnt++;
      if (wvalid) w_cnt++;
      if (awvalid && awready) aw_got = 1;
      if (wvalid && wready) w_got = 1;
      if (aw_got && w_got && !b_pend && !b_done) b_pend = 1;
    end
  endtask

  initial begin
    rst = 1'b1;
    uncache = 0; dsram_e = 0; dsram_we = 0; dsram_sel = 0;
    dsram_addr = 0; dsram_wdata = 0;
    arready = 0; rdata_i = 0; rresp = 0; rvalid = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    last_rdata = 0;
    #1;
    chk("reset_ctl", 64'd0, {56'd0, ctl()});
    chk("reset_rdata", 64'd0, rdata);
    chk("reset_araddr", 64'd0, araddr);
    chk("reset_wdata", 64'd0, wdata);
    @(negedge clk);
    rst = 1'b0;

    do_read(64'hA000_0048, 64'h1122_3344_5566_7788, 0, 0, 2'b00, 1'b0);
    do_write(64'hA000_0100, 64'h0000_0000_DEAD_BEEF, 8'h0F, 0, 3, 0, 2'b00);
    @(negedge clk);
    chk("rdata_held", 64'h1122_3344_5566_7788, rdata);

    // Cached requests plus stray responses must never start anything
    for (int i = 0; i < 10; i++) begin
      dsram_e = 1; uncache = 0; dsram_we = i[0];
      dsram_addr = {$urandom, $urandom};
      rvalid = 1; bvalid = 1; rresp = 2'b10; bresp = 2'b10;
      @(negedge clk);
      chk($sformatf("cached_ctl %0d", i), 64'd0, {56'd0, ctl()});
    end
    dsram_e = 0; rvalid = 0; bvalid = 0;

    // Request held through DONE: second read begins right after IDLE
    do_read(64'hA000_0200, 64'h0102_0304_0506_0708, 1, 0, 2'b00, 1'b1);
    do_read(64'hA000_0200, 64'hCAFE_F00D_1234_5678, 0, 1, 2'b00, 1'b0);

    do_write(64'hA000_0300, 64'h5555_AAAA_5555_AAAA, 8'hFF, 1, 1, 1, 2'b10);
    do_read(64'hA000_0308, 64'h0BAD_0BAD_0BAD_0BAD, 0, 0, 2'b10, 1'b0);

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_read({$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 2'($urandom), 1'b0);
      else
        do_write({$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 2'($urandom));
      @(negedge clk);
      chk($sformatf("rnd_idle %0d", i), 64'd0, {56'd0, ctl()});
      chk($sformatf("rnd_rdata_hold %0d", i), last_rdata, rdata);
    end

    // Reset while waiting in RDATA
    dsram_e = 1; uncache = 1; dsram_we = 0; dsram_addr = 64'h8000_0010;
    dsram_wdata = 64'h1234; dsram_sel = 8'hFF; arready = 1; rvalid = 0;
    @(negedge clk);
    dsram_e = 0;
    @(negedge clk);
    arready = 0;
    chk("pre_rst_ctl", 64'h42, {56'd0, ctl()});
    #2 rst = 1'b1;
    #1;
    chk("midrst_ctl", 64'd0, {56'd0, ctl()});
    chk("midrst_araddr", 64'd0, araddr);
    chk("midrst_awaddr", 64'd0, awaddr);
    chk("midrst_wstrb", 64'd0, {56'd0, wstrb});
    chk("midrst_rdata", 64'd0, rdata);
    @(negedge clk);
    rst = 1'b0;
    rvalid = 1; rdata_i = 64'hFFFF_0000_FFFF_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("postrst_ctl %0d", i), 64'd0, {56'd0, ctl()});
    end
    rvalid = 0;
    chk("postrst_rdata", 64'd0, rdata);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
